// File: rtl/hazard_control_unit.sv
// Stall/flush sequencer for the 5-stage pipeline: drives hold, flush and busywait
// controls of the pipeline registers and keeps saturating stall/flush counters.
module hazard_control_unit #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 IF_BUSYWAIT,
  input  logic                 MEM_BUSYWAIT,
  input  logic [4:0]           ID_RS1,
  input  logic [4:0]           ID_RS2,
  input  logic                 ID_RS1_USED,
  input  logic                 ID_RS2_USED,
  input  logic                 EX_MEM_READ,
  input  logic [4:0]           EX_RD,
  input  logic                 EX_REDIRECT,
  output logic                 PC_HOLD,
  output logic                 IF_ID_HOLD,
  output logic                 IF_ID_FLUSH,
  output logic                 ID_EX_HOLD,
  output logic                 ID_EX_FLUSH,
  output logic                 BUSYWAIT_OUT,
  output logic                 REDIRECT_PENDING,
  output logic [CNT_WIDTH-1:0] STALL_CNT,
  output logic [CNT_WIDTH-1:0] FLUSH_CNT
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    DFREEZE   = 2'd1,
    IREDIRECT = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t state, next_state;
  logic   load_use;
  logic   rs1_match;
  logic   rs2_match;
  logic   redirect_taken;

  assign rs1_match = ID_RS1_USED && (ID_RS1 == EX_RD);
  assign rs2_match = ID_RS2_USED && (ID_RS2 == EX_RD);
  assign load_use  = EX_MEM_READ && (EX_RD != 5'd0) && (rs1_match || rs2_match);

  assign REDIRECT_PENDING = (state == IREDIRECT);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Priority chain: reset, data freeze, pending redirect, new redirect, load-use, fetch stall.
  // DFREEZE behaves like RUN once MEM_BUSYWAIT drops.
  always_comb begin
    PC_HOLD        = 1'b0;
    IF_ID_HOLD     = 1'b0;
    IF_ID_FLUSH    = 1'b0;
    ID_EX_HOLD     = 1'b0;
    ID_EX_FLUSH    = 1'b0;
    BUSYWAIT_OUT   = 1'b0;
    redirect_taken = 1'b0;
    next_state     = RUN;
    if (RESET) begin
      IF_ID_FLUSH = 1'b1;
      ID_EX_FLUSH = 1'b1;
    end else if (MEM_BUSYWAIT) begin
      PC_HOLD      = 1'b1;
      IF_ID_HOLD   = 1'b1;
      ID_EX_HOLD   = 1'b1;
      BUSYWAIT_OUT = 1'b1;
      next_state   = (state == IREDIRECT) ? IREDIRECT : DFREEZE;
    end else if (state == IREDIRECT) begin
      PC_HOLD     = 1'b1;
      IF_ID_FLUSH = 1'b1;
      next_state  = IF_BUSYWAIT ? IREDIRECT : RUN;
    end else if (EX_REDIRECT) begin
      IF_ID_FLUSH    = 1'b1;
      ID_EX_FLUSH    = 1'b1;
      redirect_taken = 1'b1;
      next_state     = IF_BUSYWAIT ? IREDIRECT : RUN;
    end else if (load_use) begin
      PC_HOLD     = 1'b1;
      IF_ID_HOLD  = 1'b1;
      ID_EX_FLUSH = 1'b1;
    end else if (IF_BUSYWAIT) begin
      PC_HOLD     = 1'b1;
      IF_ID_FLUSH = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      STALL_CNT <= '0;
      FLUSH_CNT <= '0;
    end else begin
      if (PC_HOLD && (STALL_CNT != CNT_MAX)) begin
        STALL_CNT <= STALL_CNT + 1'b1;
      end
      if (redirect_taken && (FLUSH_CNT != CNT_MAX)) begin
        FLUSH_CNT <= FLUSH_CNT + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed, table-driven bench for hazard_control_unit plus a counter saturation run.
module tb_hazard_control_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IF_BUSYWAIT;
  logic        MEM_BUSYWAIT;
  logic [4:0]  ID_RS1;
  logic [4:0]  ID_RS2;
  logic        ID_RS1_USED;
  logic        ID_RS2_USED;
  logic        EX_MEM_READ;
  logic [4:0]  EX_RD;
  logic        EX_REDIRECT;
  logic        PC_HOLD;
  logic        IF_ID_HOLD;
  logic        IF_ID_FLUSH;
  logic        ID_EX_HOLD;
  logic        ID_EX_FLUSH;
  logic        BUSYWAIT_OUT;
  logic        REDIRECT_PENDING;
  logic [15:0] STALL_CNT;
  logic [15:0] FLUSH_CNT;

  int passCount  = 0;
  int checkCount = 0;

  hazard_control_unit #(.CNT_WIDTH(16)) dut (
    .CLK(CLK), .RESET(RESET), .IF_BUSYWAIT(IF_BUSYWAIT), .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .ID_RS1(ID_RS1), .ID_RS2(ID_RS2), .ID_RS1_USED(ID_RS1_USED), .ID_RS2_USED(ID_RS2_USED),
    .EX_MEM_READ(EX_MEM_READ), .EX_RD(EX_RD), .EX_REDIRECT(EX_REDIRECT),
    .PC_HOLD(PC_HOLD), .IF_ID_HOLD(IF_ID_HOLD), .IF_ID_FLUSH(IF_ID_FLUSH),
    .ID_EX_HOLD(ID_EX_HOLD), .ID_EX_FLUSH(ID_EX_FLUSH), .BUSYWAIT_OUT(BUSYWAIT_OUT),
    .REDIRECT_PENDING(REDIRECT_PENDING), .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
  );

  always #5 CLK = ~CLK;

  // Expected controls packed as {PC_HOLD, IF_ID_HOLD, IF_ID_FLUSH, ID_EX_HOLD, ID_EX_FLUSH, BUSYWAIT_OUT, REDIRECT_PENDING}
  typedef struct {
    logic        rst, mbw, ibw, redir, mr;
    logic [4:0]  rd, rs1, rs2;
    logic        u1, u2;
    logic [6:0]  ctl;
    logic [15:0] scnt, fcnt;
  } vec_t;

  localparam logic [6:0] C_IDLE  = 7'b0000000;
  localparam logic [6:0] C_FLUSH = 7'b0010100;
  localparam logic [6:0] C_LU    = 7'b1100100;
  localparam logic [6:0] C_IRED  = 7'b1010001;
  localparam logic [6:0] C_IFST  = 7'b1010000;
  localparam logic [6:0] C_FRZ   = 7'b1101010;
  localparam logic [6:0] C_FRZIR = 7'b1101011;
  localparam logic [6:0] C_RSTIR = 7'b0010101;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic mbw, logic ibw, logic redir, logic mr,
                              logic [4:0] rd, logic [4:0] rs1, logic u1, logic [4:0] rs2,
                              logic u2, logic [6:0] ctl, int s, int f);
    vec_t v;
    v.rst = rst; v.mbw = mbw; v.ibw = ibw; v.redir = redir; v.mr = mr;
    v.rd = rd; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.ctl = ctl; v.scnt = 16'(s); v.fcnt = 16'(f);
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    RESET = v.rst; MEM_BUSYWAIT = v.mbw; IF_BUSYWAIT = v.ibw; EX_REDIRECT = v.redir;
    EX_MEM_READ = v.mr; EX_RD = v.rd; ID_RS1 = v.rs1; ID_RS1_USED = v.u1;
    ID_RS2 = v.rs2; ID_RS2_USED = v.u2;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic checkVec(input string tag, input vec_t v);
    checkOutput({tag, " PC_HOLD"},          16'(PC_HOLD),          16'(v.ctl[6]));
    checkOutput({tag, " IF_ID_HOLD"},       16'(IF_ID_HOLD),       16'(v.ctl[5]));
    checkOutput({tag, " IF_ID_FLUSH"},      16'(IF_ID_FLUSH),      16'(v.ctl[4]));
    checkOutput({tag, " ID_EX_HOLD"},       16'(ID_EX_HOLD),       16'(v.ctl[3]));
    checkOutput({tag, " ID_EX_FLUSH"},      16'(ID_EX_FLUSH),      16'(v.ctl[2]));
    checkOutput({tag, " BUSYWAIT_OUT"},     16'(BUSYWAIT_OUT),     16'(v.ctl[1]));
    checkOutput({tag, " REDIRECT_PENDING"}, 16'(REDIRECT_PENDING), 16'(v.ctl[0]));
    checkOutput({tag, " STALL_CNT"},        STALL_CNT,             v.scnt);
    checkOutput({tag, " FLUSH_CNT"},        FLUSH_CNT,             v.fcnt);
  endtask

  initial begin
    // Counters listed per vector are the values visible before that cycle's edge.
    //              rst mbw ibw red mr  rd     rs1   u1  rs2   u2  ctl      s   f
    vecs.push_back(mk(1, 1, 1, 1, 1, 5'd5, 5'd5, 1, 5'd5, 1, C_FLUSH,  0,  0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IDLE,   0,  0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 5'd5, 5'd3, 1, 5'd5, 1, C_LU,     0,  0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IDLE,   1,  0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 5'd0, 5'd3, 1, 5'd0, 1, C_IDLE,   1,  0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 5'd7, 5'd7, 0, 5'd2, 1, C_IDLE,   1,  0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 5'd5, 5'd1, 1, 5'd5, 1, C_IDLE,   1,  0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 5'd9, 5'd9, 1, 5'd4, 0, C_LU,     1,  0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_FLUSH,  2,  0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IDLE,   2,  1));
    vecs.push_back(mk(0, 0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_FLUSH,  2,  1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IRED,   2,  2));
    vecs.push_back(mk(0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IRED,   3,  2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IRED,   4,  2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IDLE,   5,  2));
    vecs.push_back(mk(0, 1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_FRZ,    5,  2));
    vecs.push_back(mk(0, 1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_FRZ,    6,  2));
    vecs.push_back(mk(0, 1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_FRZ,    7,  2));
    vecs.push_back(mk(0, 1, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_FRZ,    8,  2));
    vecs.push_back(mk(0, 0, 0, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_FLUSH,  9,  2));
    vecs.push_back(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IDLE,   9,  3));
    vecs.push_back(mk(0, 0, 0, 1, 1, 5'd6, 5'd6, 1, 5'd0, 0, C_FLUSH,  9,  3));
    vecs.push_back(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IDLE,   9,  4));
    vecs.push_back(mk(0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IFST,   9,  4));
    vecs.push_back(mk(0, 0, 1, 0, 1, 5'd8, 5'd0, 0, 5'd8, 1, C_LU,    10,  4));
    vecs.push_back(mk(0, 1, 0, 0, 1, 5'd8, 5'd0, 0, 5'd8, 1, C_FRZ,   11,  4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IDLE,  12,  4));
    vecs.push_back(mk(0, 0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_FLUSH, 12,  4));
    vecs.push_back(mk(0, 1, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_FRZIR, 12,  5));
    vecs.push_back(mk(0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IRED,  13,  5));
    vecs.push_back(mk(1, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_RSTIR, 14,  5));
    vecs.push_back(mk(1, 0, 1, 1, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_FLUSH,  0,  0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IDLE,   0,  0));

    applyStimulus(mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IDLE, 0, 0));
    @(negedge CLK);
    @(negedge CLK);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #1;
      checkVec($sformatf("v%0d", i), vecs[i]);
      @(negedge CLK);
    end

    // Long fetch stall drives STALL_CNT to 0xFFFE, then three more cycles saturate it.
    applyStimulus(mk(0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, C_IFST, 0, 0));
    repeat (65534) @(negedge CLK);
    #1;
    checkOutput("sat pre STALL_CNT", STALL_CNT, 16'hFFFE);
    checkOutput("sat pre PC_HOLD", 16'(PC_HOLD), 16'd1);
    repeat (3) @(negedge CLK);
    #1;
    checkOutput("sat STALL_CNT", STALL_CNT, 16'hFFFF);
    checkOutput("sat FLUSH_CNT", FLUSH_CNT, 16'h0000);
    IF_BUSYWAIT = 1'b0;
    @(negedge CLK);
    #1;
    checkOutput("sat hold STALL_CNT", STALL_CNT, 16'hFFFF);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
